// File: rtl/credit_link_tx.sv
`default_nettype none
// =============================================================================
// Module   : credit_link_tx
// Purpose  : Credit-gated transmit end of a point-to-point link with a small
//            word FIFO, tagging each word with destination and source rank.
// Revision : 1.0 - initial release
// =============================================================================
module credit_link_tx #(
   parameter int DATA_WIDTH   = 64,
   parameter int FIFO_DEPTH   = 4,
   parameter int CREDIT_WIDTH = 3,
   parameter int INIT_CREDITS = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   input  logic [DATA_WIDTH-1:0]         in_data,
   input  logic [31:0]                   in_dest,
   output logic                          in_ready,
   input  logic [31:0]                   rnk,
   output logic                          link_valid,
   output logic [DATA_WIDTH-1:0]         link_data,
   output logic [31:0]                   link_dest,
   output logic [31:0]                   link_src,
   input  logic                          yumi,
   output logic [CREDIT_WIDTH-1:0]       credit_count,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          credit_err
);

   localparam int                        c_ADDR_W     = $clog2(FIFO_DEPTH);
   localparam logic [c_ADDR_W:0]         c_FULL       = (c_ADDR_W+1)'(FIFO_DEPTH);
   localparam logic [c_ADDR_W:0]         c_CNT_ONE    = (c_ADDR_W+1)'(1);
   localparam logic [c_ADDR_W-1:0]       c_PTR_ONE    = c_ADDR_W'(1);
   localparam logic [CREDIT_WIDTH-1:0]   c_CRED_ONE   = CREDIT_WIDTH'(1);
   localparam logic [CREDIT_WIDTH-1:0]   c_CRED_MAX   = '1;
   localparam logic [CREDIT_WIDTH-1:0]   c_CRED_INIT  = CREDIT_WIDTH'(INIT_CREDITS);

   logic [DATA_WIDTH-1:0]   r_mem_data [FIFO_DEPTH];
   logic [31:0]             r_mem_dest [FIFO_DEPTH];
   logic [c_ADDR_W-1:0]     r_wr_ptr;
   logic [c_ADDR_W-1:0]     r_rd_ptr;
   logic [c_ADDR_W:0]       r_count;
   logic [CREDIT_WIDTH-1:0] r_credit;
   logic                    r_err;
   logic                    r_link_valid;
   logic [DATA_WIDTH-1:0]   r_link_data;
   logic [31:0]             r_link_dest;
   logic [31:0]             r_link_src;

   logic                    w_push;
   logic                    w_send;

   // Full is judged on the registered count only, so a same-cycle pop never frees a slot.
   assign in_ready = !rst && (r_count != c_FULL);
   assign w_push   = in_valid && in_ready;
   assign w_send   = (r_count != '0) && (r_credit != '0);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_data[r_wr_ptr] <= in_data;
         r_mem_dest[r_wr_ptr] <= in_dest;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         if (w_send) r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         case ({w_push, w_send})
            2'b10:   r_count <= r_count + c_CNT_ONE;
            2'b01:   r_count <= r_count - c_CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_credit <= c_CRED_INIT;
         r_err    <= 1'b0;
      end else begin
         case ({w_send, yumi})
            2'b10:   r_credit <= r_credit - c_CRED_ONE;
            2'b01: begin
               if (r_credit == c_CRED_MAX) r_err <= 1'b1;
               else                        r_credit <= r_credit + c_CRED_ONE;
            end
            default: r_credit <= r_credit;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_link_valid <= 1'b0;
         r_link_data  <= '0;
         r_link_dest  <= '0;
         r_link_src   <= '0;
      end else begin
         r_link_valid <= w_send;
         if (w_send) begin
            r_link_data <= r_mem_data[r_rd_ptr];
            r_link_dest <= r_mem_dest[r_rd_ptr];
            r_link_src  <= rnk;
         end
      end
   end

   assign link_valid   = r_link_valid;
   assign link_data    = r_link_data;
   assign link_dest    = r_link_dest;
   assign link_src     = r_link_src;
   assign credit_count = r_credit;
   assign fifo_count   = r_count;
   assign credit_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_credit_link_tx.sv
`default_nettype none
// =============================================================================
// Module   : tb_credit_link_tx
// Purpose  : Directed bench for credit_link_tx with a queue-based reference.
// Revision : 1.0 - initial release
// =============================================================================
module tb_credit_link_tx;

   localparam int DW    = 64;
   localparam int DEPTH = 4;
   localparam int CMAX  = 7;
   localparam int INIT  = 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic [31:0]   in_dest;
   logic          in_ready;
   logic [31:0]   rnk;
   logic          link_valid;
   logic [DW-1:0] link_data;
   logic [31:0]   link_dest;
   logic [31:0]   link_src;
   logic          yumi;
   logic [2:0]    credit_count;
   logic [2:0]    fifo_count;
   logic          credit_err;

   credit_link_tx #(
      .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CREDIT_WIDTH(3), .INIT_CREDITS(INIT)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_data(in_data), .in_dest(in_dest), .in_ready(in_ready),
      .rnk(rnk),
      .link_valid(link_valid), .link_data(link_data), .link_dest(link_dest), .link_src(link_src),
      .yumi(yumi), .credit_count(credit_count), .fifo_count(fifo_count), .credit_err(credit_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;
   int pulses   = 0;
   int p0;
   bit chk_en   = 1'b0;
   logic [DW-1:0] got [$];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   // Reference: a queue of {dest,data} plus an integer credit counter.
   logic [95:0] q [$];
   int          m_credit = INIT;
   bit          m_err    = 1'b0;
   logic        m_valid  = 1'b0;
   logic [63:0] m_data   = '0;
   logic [31:0] m_dest   = '0;
   logic [31:0] m_src    = '0;
   bit          snd, psh;
   logic [95:0] ent;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q.delete();
         m_credit = INIT;
         m_err    = 1'b0;
         m_valid  = 1'b0;
         m_data   = '0;
         m_dest   = '0;
         m_src    = '0;
      end else begin
         snd = (q.size() != 0) && (m_credit != 0);
         psh = in_valid && (q.size() < DEPTH);
         m_valid = snd;
         if (snd) begin
            ent    = q.pop_front();
            m_dest = ent[95:64];
            m_data = ent[63:0];
            m_src  = rnk;
         end
         if (psh) q.push_back({in_dest, in_data});
         if (snd && !yumi)      m_credit = m_credit - 1;
         else if (!snd && yumi) begin
            if (m_credit == CMAX) m_err = 1'b1;
            else                  m_credit = m_credit + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("link_valid",   64'(link_valid),   64'(m_valid));
         check("link_data",    link_data,         m_data);
         check("link_dest",    64'(link_dest),    64'(m_dest));
         check("link_src",     64'(link_src),     64'(m_src));
         check("credit_count", 64'(credit_count), 64'(m_credit));
         check("fifo_count",   64'(fifo_count),   64'(q.size()));
         check("in_ready",     64'(in_ready),     64'(!rst && (q.size() < DEPTH)));
         check("credit_err",   64'(credit_err),   64'(m_err));
         if (link_valid) begin
            pulses++;
            got.push_back(link_data);
         end
      end
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_dest = '0; rnk = '0; yumi = 1'b0;
      tick();
      chk_en = 1'b1;
      tick();
      rst = 1'b0;
      #1 check("ready_after_reset", 64'(in_ready), 64'd1);

      // Single word, two-edge latency
      in_valid = 1'b1; in_data = 64'hdeedabba_cafeface; in_dest = 32'd2;
      tick();
      in_valid = 1'b0;
      check("sw_not_yet", 64'(link_valid), 64'd0);
      check("sw_fifo1", 64'(fifo_count), 64'd1);
      tick();
      check("sw_valid", 64'(link_valid), 64'd1);
      check("sw_data", link_data, 64'hdeedabba_cafeface);
      check("sw_dest", 64'(link_dest), 64'd2);
      check("sw_src", 64'(link_src), 64'd0);
      check("sw_credit0", 64'(credit_count), 64'd0);

      // Asynchronous reset mid-cycle while link_valid is high
      #2 rst = 1'b1;
      #1;
      check("ar_valid", 64'(link_valid), 64'd0);
      check("ar_credit", 64'(credit_count), 64'd1);
      check("ar_fifo", 64'(fifo_count), 64'd0);
      check("ar_ready", 64'(in_ready), 64'd0);
      tick();
      rst = 1'b0;
      #1 check("ar_ready_rel", 64'(in_ready), 64'd1);

      // Credit stall
      p0 = pulses;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = 64'h1000 + 64'(i); in_dest = 32'(i + 3);
         tick();
      end
      in_valid = 1'b0;
      tick(); tick();
      check("cs_pulses", 64'(pulses - p0), 64'd1);
      check("cs_fifo", 64'(fifo_count), 64'd2);
      yumi = 1'b1; tick(); yumi = 1'b0;
      check("cs_yumi_nosend", 64'(link_valid), 64'd0);
      check("cs_credit1", 64'(credit_count), 64'd1);
      tick();
      check("cs_second", link_data, 64'h1001);
      check("cs_credit0", 64'(credit_count), 64'd0);
      yumi = 1'b1; tick(); yumi = 1'b0;
      tick();
      check("cs_third", link_data, 64'h1002);

      // Full FIFO, ordering and pointer wrap
      for (int r = 0; r < 2; r++) begin
         got.delete();
         for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 64'hA0 + 64'(16 * r + i); in_dest = 32'd9;
            tick();
         end
         in_data = 64'hBAD;
         check("ff_ready0", 64'(in_ready), 64'd0);
         tick();
         check("ff_fifo4", 64'(fifo_count), 64'd4);
         yumi = 1'b1;
         tick(); tick();
         in_valid = 1'b0;
         check("ff_nobypass", 64'(fifo_count), 64'd3);
         tick(); tick();
         yumi = 1'b0;
         tick(); tick();
         check("ff_count", 64'(got.size()), 64'd4);
         for (int i = 0; i < 4; i++)
            if (i < got.size()) check("ff_order", got[i], 64'hA0 + 64'(16 * r + i));
         check("ff_credit0", 64'(credit_count), 64'd0);
      end

      // Simultaneous send and yumi
      yumi = 1'b1; tick(); yumi = 1'b0;
      in_valid = 1'b1; in_data = 64'h5A5A; in_dest = 32'd4;
      tick();
      in_valid = 1'b0; yumi = 1'b1;
      tick();
      yumi = 1'b0;
      check("sy_valid", 64'(link_valid), 64'd1);
      check("sy_credit1", 64'(credit_count), 64'd1);
      p0 = pulses;
      in_valid = 1'b1; yumi = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_data = 64'h700 + 64'(i);
         tick();
      end
      in_valid = 1'b0;
      tick();
      yumi = 1'b0;
      check("sy_pulses", 64'(pulses - p0), 64'd8);
      check("sy_credit2", 64'(credit_count), 64'd2);

      // Saturation, then reset with words buffered
      #2 rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      yumi = 1'b1;
      repeat (6) tick();
      check("sat_credit7", 64'(credit_count), 64'd7);
      check("sat_err0", 64'(credit_err), 64'd0);
      tick();
      yumi = 1'b0;
      check("sat_hold7", 64'(credit_count), 64'd7);
      check("sat_err1", 64'(credit_err), 64'd1);
      p0 = pulses;
      for (int i = 0; i < 9; i++) begin
         in_valid = 1'b1; in_data = 64'hE00 + 64'(i); in_dest = 32'd1;
         tick();
      end
      in_valid = 1'b0;
      tick(); tick();
      check("sat_pulses", 64'(pulses - p0), 64'd7);
      check("sat_fifo2", 64'(fifo_count), 64'd2);
      p0 = pulses;
      #2 rst = 1'b1;
      #1;
      check("rb_fifo0", 64'(fifo_count), 64'd0);
      check("rb_err0", 64'(credit_err), 64'd0);
      tick(); tick();
      rst = 1'b0;
      tick(); tick();
      check("rb_nopulse", 64'(pulses - p0), 64'd0);
      check("rb_credit", 64'(credit_count), 64'd1);

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/credit_link_tx.md
Name: credit_link_tx

Overview:
- Transmit end of the credit-based point-to-point link; a receiver node at the far end returns one credit per consumed word via `yumi`.
- Accepts 64-bit words plus destination rank from a local producer through a valid/ready handshake.
- Buffers words in a small FIFO and issues them onto the link only while credits are available.
- Tags each outgoing word with destination and source rank for the testbench-level message layer.

Parameters:
- DATA_WIDTH, 64, payload width of link_data and in_data.
- FIFO_DEPTH, 4, transmit buffer entries; power of two, at least 2.
- CREDIT_WIDTH, 3, width of the credit counter; maximum credit is 2^CREDIT_WIDTH-1.
- INIT_CREDITS, 1, credit count loaded at reset; must be at most 2^CREDIT_WIDTH-1.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer has a word.
- in_data  input  DATA_WIDTH  producer payload.
- in_dest  input  32  destination rank, captured with the word.
- in_ready  output  1  FIFO can accept a word this cycle.
- rnk  input  32  this node's rank; static after reset.
- link_valid  output  1  one-cycle pulse, one word on the link.
- link_data  output  DATA_WIDTH  payload, valid while link_valid is high.
- link_dest  output  32  destination rank of link_data.
- link_src  output  32  source rank (rnk) of link_data.
- yumi  input  1  credit return pulse from receiver, +1 credit per cycle high.
- credit_count  output  CREDIT_WIDTH  current credit register.
- fifo_count  output  log2(FIFO_DEPTH)+1  current FIFO occupancy.
- credit_err  output  1  sticky; a credit return arrived while credits were saturated.

Behaviour:
Reset
- Asynchronous, active-high; takes effect immediately, independent of clk.
- FIFO empties (pointers and count go to 0).
- credit_count becomes INIT_CREDITS.
- link_valid, link_data, link_dest, link_src and credit_err become 0.
- in_ready is 0 while rst is high.
- Words already buffered are discarded with no link pulse.
- A reset asserted while link_valid is high clears it in the same cycle.

Input handshake
- in_ready = !rst && (fifo_count != FIFO_DEPTH).
- Push occurs on a rising edge where in_valid && in_ready; in_data and in_dest are stored together.
- No push-through-pop bypass: when full, in_ready stays 0 even if a pop happens in the same cycle.

Send decision
- Combinational: send = (fifo_count != 0) && (credit_count != 0).
- On send, the head entry is popped and loaded at the edge into the link_data, link_dest and link_src registers (link_src = rnk); link_valid is registered as 1.
- Otherwise link_valid is registered as 0 and link_data holds its previous value.
- The link has no backpressure; credits guarantee receiver space.

Latency
- A word pushed at edge E into an empty FIFO with credit > 0 appears with link_valid high in the cycle after edge E+1 (2 edges).
- Back-to-back sends run at one per cycle while credit and data last.

Credits
- credit_next = credit - send + yumi.
- send and yumi together: credit unchanged.
- yumi in a cycle where credit_count == 0 does not enable a send in that cycle; the new credit is usable the next cycle.
- Saturation: if yumi && !send && credit_count == 2^CREDIT_WIDTH-1, the counter holds and credit_err sets; credit_err stays set until reset.
- Credit never underflows; send is gated by credit != 0.

Ordering
- Words leave in strict FIFO order.
- Read and write pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.

Test Plan:
- Reset behaviour: assert rst mid-cycle with no clk edge -> link_valid=0, credit_count=1, fifo_count=0, in_ready=0 immediately; after release, in_ready=1.
- Single word: push 64'hdeedabba_cafeface, dest=2, rnk=0, credit=1 -> link_valid pulses once, 2 edges after push, with link_dest=2, link_src=0; credit_count becomes 0.
- Credit stall: push 3 words with INIT_CREDITS=1 and no yumi -> exactly 1 link pulse and fifo_count=2. Pulse yumi once -> second word sent next cycle; credit returns to 0.
- Full FIFO: hold credit at 0 and push 4 words -> in_ready=0, and a fifth in_valid is not accepted. Then yumi 4 times -> 4 words emerge in push order, and pointers wrap cleanly on a further 4 pushes.
- Simultaneous send and yumi: credit=1, data present, yumi high in the send cycle -> link_valid pulse, credit_count stays 1; sustained yumi every cycle gives 1 word per cycle.
- Saturation and reset: drive credit to 7 with yumi while the FIFO is empty, then one more yumi -> credit_count stays 7 and credit_err=1. Then assert rst with 2 words buffered -> FIFO empties with no link pulse, and credit_err clears.
